// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared AES types, FSM encoding, S-box tables and GF(2^8) helpers for the iterative decryptor.
// Byte 0 of a 128-bit state sits in [127:120]; columns are consecutive 32-bit words.
package aes128_decrypt_iter_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } fsm_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic byte_t inv_sbox(input byte_t b);
        return INV_SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Round constants 1..10; any other index yields 0.
    function automatic byte_t rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 24'h0}
    function automatic word_t sub_rot(input word_t w, input byte_t rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic word_t inv_mix_col(input word_t c);
        byte_t a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// Ciphertext/key input handshake, plaintext output handshake and busy status of the decryptor.
interface aes128_decrypt_iter_if;
    import aes128_decrypt_iter_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t cipher_text;
    state_t cipher_key;
    logic   out_valid;
    logic   out_ready;
    state_t plain_text;
    logic   busy;

    modport master (
        output in_valid, cipher_text, cipher_key, out_ready,
        input  in_ready, out_valid, plain_text, busy
    );

    modport slave (
        input  in_valid, cipher_text, cipher_key, out_ready,
        output in_ready, out_valid, plain_text, busy
    );
endinterface

// File: rtl/aes128_decrypt_iter_inv_round.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last_round.
// Purely combinational; no handshake.
module aes128_decrypt_iter_inv_round
    import aes128_decrypt_iter_pkg::*;
(
    input  state_t state_in,
    input  state_t round_key,
    input  logic   last_round,
    output state_t state_out
);

    state_t isr;
    state_t ark;
    state_t imc;

    always_comb begin
        isr = '0;
        // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                isr[127 - 8 * (r + 4 * c) -: 8] = state_in[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
    end

    always_comb begin
        ark = '0;
        for (int i = 0; i < 16; i++) begin
            ark[127 - 8 * i -: 8] = inv_sbox(isr[127 - 8 * i -: 8]) ^ round_key[127 - 8 * i -: 8];
        end
    end

    always_comb begin
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            imc[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
        end
    end

    assign state_out = last_round ? ark : imc;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock; AES_DEC_KEY_CACHE_EN adds a last-key/rk10 cache.
// Latency 21 cycles accept-to-valid (11 on cache hit); result held until out_ready, in_ready only when idle.
module aes128_decrypt_iter
    import aes128_decrypt_iter_pkg::*;
#(
    parameter int ZERO_ON_IDLE = 1
)
(
    input  logic clk,
    input  logic rst_n,
    aes128_decrypt_iter_if.slave bus
);

    fsm_e       state;
    logic [3:0] rnd;
    state_t     ct_q;
    state_t     key_q;
    state_t     state_q;

    state_t     rk_fwd;
    state_t     rk_prev;
    state_t     round_out;
    logic       hit;
    state_t     hit_key;

    function automatic state_t fwd_step(input state_t k, input byte_t rc);
        word_t w4, w5, w6, w7;
        w4 = k[127:96] ^ sub_rot(k[31:0], rc);
        w5 = k[95:64] ^ w4;
        w6 = k[63:32] ^ w5;
        w7 = k[31:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    // Undo one forward step: recover round key i-1 from round key i.
    function automatic state_t inv_step(input state_t k, input byte_t rc);
        word_t w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    assign rk_fwd  = fwd_step(key_q, rcon(rnd));
    assign rk_prev = inv_step(key_q, rcon(rnd + 4'd1));

    aes128_decrypt_iter_inv_round u_round (
        .state_in   (state_q),
        .round_key  (rk_prev),
        .last_round (rnd == 4'd0),
        .state_out  (round_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    state_t tag_q;
    state_t rk10_q;
    logic   cache_vld_q;

    assign hit     = cache_vld_q && (bus.cipher_key == tag_q);
    assign hit_key = rk10_q;

    // Tag is captured at accept; the entry only becomes valid once rk10 lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            rk10_q      <= '0;
            cache_vld_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid && !hit) begin
            tag_q       <= bus.cipher_key;
            cache_vld_q <= 1'b0;
        end else if (state == EXPAND && rnd == 4'd10) begin
            rk10_q      <= rk_fwd;
            cache_vld_q <= 1'b1;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_key = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rnd     <= '0;
            ct_q    <= '0;
            key_q   <= '0;
            state_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (hit) begin
                            state_q <= bus.cipher_text ^ hit_key;
                            key_q   <= hit_key;
                            rnd     <= 4'd9;
                            state   <= ROUND;
                        end else begin
                            ct_q  <= bus.cipher_text;
                            key_q <= bus.cipher_key;
                            rnd   <= 4'd1;
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    key_q <= rk_fwd;
                    if (rnd == 4'd10) begin
                        state_q <= ct_q ^ rk_fwd;
                        rnd     <= 4'd9;
                        state   <= ROUND;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ROUND: begin
                    key_q   <= rk_prev;
                    state_q <= round_out;
                    if (rnd == 4'd0) state <= DONE;
                    else             rnd   <= rnd - 4'd1;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.plain_text = (ZERO_ON_IDLE == 0 || state == DONE) ? state_q : '0;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, handshake corner cases, and random blocks
// produced by an independent forward-cipher model (S-box derived from GF(2^8) inversion).
module tb_aes128_decrypt_iter;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    // Model of the key cache contents as seen from outside.
    bit           cvld = 1'b0;
    logic [127:0] last_key = '0;

    logic [7:0] sb [256];

    aes128_decrypt_iter_if bus ();

    aes128_decrypt_iter #(.ZERO_ON_IDLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 400000", $time);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward AES-128 encryption; the DUT must invert it.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r < 10) begin
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Offers one block, waits for acceptance, and returns at the negedge where out_valid is first seen.
    // Latency is the index of the first rising edge after the accept edge at which out_valid is high.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt, input string nm);
        int guard;
        int lat;
        int exp_lat;
        bit is_hit;
        bus.cipher_text = ct;
        bus.cipher_key  = key;
        bus.in_valid    = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            chk({nm, " accept timeout"}, 128'(bus.in_ready), 128'd1);
            bus.in_valid = 1'b0;
            return;
        end
        is_hit  = CACHE && cvld && (key == last_key);
        exp_lat = is_hit ? 11 : 21;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " plain_text"}, bus.plain_text, pt);
        chk({nm, " in_ready in DONE"}, 128'(bus.in_ready), 128'd0);
        if (!is_hit) begin
            cvld     = 1'b1;
            last_key = key;
        end
    endtask

    vec_t         tbl [3];
    logic [127:0] k, p, c;
    int           a1, a2;

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, rt, s;
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            s = inv;
            rt = inv;
            for (int j = 0; j < 4; j++) begin
                rt = {rt[6:0], rt[7]};
                s = s ^ rt;
            end
            sb[x] = s ^ 8'h63;
        end

        tbl[0] = {128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3243f6a8885a308d313198a2e0370734};
        tbl[1] = {128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff};
        tbl[2] = {128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0};

        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.cipher_text = '0;
        bus.cipher_key  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset plain_text", bus.plain_text, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vectors
        for (int i = 0; i < 3; i++) run_block(tbl[i].ct, tbl[i].key, tbl[i].pt, $sformatf("tbl%0d", i));
        @(negedge clk);
        chk("idle plain_text zeroed", bus.plain_text, 128'd0);
        chk("idle out_valid", 128'(bus.out_valid), 128'd0);
        chk("idle busy", 128'(bus.busy), 128'd0);
        chk("idle in_ready", 128'(bus.in_ready), 128'd1);

        // Backpressure with a competing second request held on the input
        bus.out_ready = 1'b0;
        run_block(tbl[0].ct, tbl[0].key, tbl[0].pt, "bp first");
        bus.cipher_text = tbl[1].ct;
        bus.cipher_key  = tbl[1].key;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d plain_text", i), bus.plain_text, tbl[0].pt);
            chk($sformatf("bp hold%0d out_valid", i), 128'(bus.out_valid), 128'd1);
            chk($sformatf("bp hold%0d in_ready", i), 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        run_block(tbl[1].ct, tbl[1].key, tbl[1].pt, "bp second");

        // Reset in the middle of the round phase
        @(negedge clk);
        bus.cipher_text = tbl[0].ct;
        bus.cipher_key  = tbl[0].key;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("midrst busy before", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst plain_text", bus.plain_text, 128'd0);
        chk("midrst in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst busy", 128'(bus.busy), 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cvld = 1'b0;
        run_block(tbl[1].ct, tbl[1].key, tbl[1].pt, "after reset");

        // Back-to-back throughput
        run_block(tbl[0].ct, tbl[0].key, tbl[0].pt, "b2b first");
        a1 = acc_cyc;
        run_block(tbl[1].ct, tbl[1].key, tbl[1].pt, "b2b second");
        a2 = acc_cyc;
        chk("b2b accept spacing", 128'(a2 - a1), 128'd22);

        // Same key twice, then a new key
        run_block(tbl[0].ct, tbl[0].key, tbl[0].pt, "key repeat 1");
        run_block(tbl[0].ct, tbl[0].key, tbl[0].pt, "key repeat 2");
        run_block(tbl[1].ct, tbl[1].key, tbl[1].pt, "key change");

        // Random blocks; every other one reuses the previous key
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = aes_enc(p, k);
            run_block(c, k, p, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
